// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  localparam int unsigned PS2_EVENT_W = $bits(ps2_event_t);

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic first-word fall-through FIFO with occupancy and a sticky overflow flag.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_dout;
  logic             r_overflow;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_next;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_pop     = i_pop && (r_level != '0);
  assign w_push    = i_push && (!w_full || w_pop);
  assign w_rd_next = r_rd_ptr + AW'(1);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Head register keeps the last entry visible once the FIFO drains.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_dout     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      if (i_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_pop) begin
        if (r_level > LW'(1))  r_dout <= r_mem[w_rd_next];
        else if (w_push)       r_dout <= i_din;
      end else if (w_push && (r_level == '0)) begin
        r_dout <= i_din;
      end
    end
  end

  assign o_dout     = r_dout;
  assign o_full     = w_full;
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: oversampled clock filter, framed receive FSM,
// E0/F0 prefix decoder and a key-event FIFO with valid/ready handshake.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          ps2_clock,
  input  logic                          ps2_data,
  input  logic                          ready,
  output logic                          valid,
  output logic [7:0]                    code,
  output logic                          brk,
  output logic                          ext,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned FW = 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_filt_clk;
  logic [FW-1:0] r_filt_cnt;
  logic          r_sample;

  rx_state_t     r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          r_rx_vld;
  logic          r_frame_err;
  logic          r_ext_pend;
  logic          r_brk_pend;

  logic          w_differ;
  logic          w_filt_flip;
  logic          w_dat;
  logic          w_push;
  ps2_event_t    w_event;
  ps2_event_t    w_head;
  logic          w_empty;
  logic          w_unused_full;

  assign w_differ    = (r_clk_sync[1] != r_filt_clk);
  assign w_filt_flip = w_differ && (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_dat       = r_dat_sync[1];

  // Synchronisers and glitch filter; r_sample marks a filtered falling edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
      r_sample   <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clock};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      r_sample   <= w_filt_flip && !r_clk_sync[1];
      if (!w_differ) begin
        r_filt_cnt <= '0;
      end else if (w_filt_flip) begin
        r_filt_clk <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  // Frame receiver with timeout; emits a byte strobe or an error pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_to_cnt    <= '0;
      r_rx_vld    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_vld    <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_to_cnt  <= '0;
          r_bit_cnt <= '0;
          if (r_sample && !w_dat) r_state <= DATA;
        end
        default: begin
          if (r_sample) begin
            r_to_cnt <= '0;
            if (r_state == DATA) begin
              r_shift   <= {w_dat, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_state <= PARITY;
            end else if (r_state == PARITY) begin
              r_parity <= w_dat;
              r_state  <= STOP;
            end else begin
              r_state <= IDLE;
              if ((^{r_shift, r_parity}) && w_dat) r_rx_vld    <= 1'b1;
              else                                 r_frame_err <= 1'b1;
            end
          end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= IDLE;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
      endcase
    end
  end

  // Prefix tracking: prefixes arm flags, any other byte consumes them.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (r_frame_err) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (r_rx_vld) begin
      if (r_shift == PS2_EXT) begin
        r_ext_pend <= 1'b1;
      end else if (r_shift == PS2_BRK) begin
        r_brk_pend <= 1'b1;
      end else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  assign w_push = r_rx_vld && (r_shift != PS2_EXT) && (r_shift != PS2_BRK);

  always_comb begin
    w_event      = '0;
    w_event.ext  = r_ext_pend;
    w_event.brk  = r_brk_pend;
    w_event.code = r_shift;
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVENT_W)
  ) u_fifo (
    .clock      (clock),
    .rst        (rst),
    .i_push     (w_push),
    .i_din      (w_event),
    .i_pop      (ready),
    .o_dout     (w_head),
    .o_full     (w_unused_full),
    .o_empty    (w_empty),
    .o_level    (level),
    .o_overflow (overflow)
  );

  assign valid     = !w_empty;
  assign code      = w_head.code;
  assign brk       = w_head.brk;
  assign ext       = w_head.ext;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised bench for ps2_rx_fifo against a queue-based key-event model.
module tb_ps2_rx_fifo;

  localparam int unsigned FL    = 4;
  localparam int unsigned TO    = 300;
  localparam int unsigned DEPTH = 4;
  localparam int          HALF  = 12;
  localparam int          GAP   = 30;

  logic                       clock;
  logic                       rst;
  logic                       ps2_clock;
  logic                       ps2_data;
  logic                       ready;
  logic                       valid;
  logic [7:0]                 code;
  logic                       brk;
  logic                       ext;
  logic                       frame_err;
  logic                       overflow;
  logic [$clog2(DEPTH):0]     level;

  ps2_rx_fifo #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .ready     (ready),
    .valid     (valid),
    .code      (code),
    .brk       (brk),
    .ext       (ext),
    .frame_err (frame_err),
    .overflow  (overflow),
    .level     (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: expected events, pending prefixes, error count.
  logic [9:0] exp_q[$];
  bit         m_ext;
  bit         m_brk;
  bit         exp_ovf;
  int         exp_err;
  int         err_seen;
  int         v_cycles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted head is compared with the model's oldest entry.
  always @(negedge clock) begin
    if (rst) begin
      if (valid) v_cycles++;
      if (frame_err) err_seen++;
      if (valid && ready) begin
        chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("pop_event", 32'({ext, brk, code}), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++;
      model_clear();
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back({m_ext, m_brk, b});
      model_clear();
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clock = 1'b0;
    cyc(HALF);
    ps2_clock = 1'b1;
  endtask

  // Low pulse one cycle too short to pass the filter.
  task automatic glitch();
    cyc(HALF);
    ps2_clock = 1'b0;
    cyc(FL - 1);
    ps2_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_v,
                            input int nbits, input int gi);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = (~^b) ^ par_flip;
    bits[10]  = stop_v;
    for (int i = 0; i < nbits; i++) begin
      if (i == gi) begin
        ps2_data = bits[i];
        glitch();
      end
      send_bit(bits[i]);
    end
    ps2_data = 1'b1;
    cyc(GAP);
  endtask

  task automatic frame(input logic [7:0] b, input logic par_flip, input logic stop_v, input int gi);
    model_frame(b, !par_flip && stop_v);
    send_frame(b, par_flip, stop_v, 11, gi);
  endtask

  task automatic settle(input string tag);
    cyc(20);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_errs"}, 32'(err_seen), 32'(exp_err));
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] c;
    c = 8'($urandom_range(0, 255));
    while (c == 8'hE0 || c == 8'hF0) c = 8'($urandom_range(0, 255));
    return c;
  endfunction

  initial begin
    logic [7:0] c;
    logic [7:0] last;
    int         r;
    rst = 1'b0; ps2_clock = 1'b1; ps2_data = 1'b1; ready = 1'b1;
    exp_err = 0; err_seen = 0; v_cycles = 0; exp_ovf = 1'b0;
    model_clear();
    cyc(3);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_brk", 32'(brk), 32'd0);
    chk("rst_ext", 32'(ext), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    rst = 1'b1;
    cyc(5);

    v_cycles = 0;
    frame(8'h1C, 1'b0, 1'b1, -1);
    settle("t1");
    chk("t1_valid_width", 32'(v_cycles), 32'd1);

    frame(8'hF0, 1'b0, 1'b1, -1);
    frame(8'h1C, 1'b0, 1'b1, -1);
    frame(8'hE0, 1'b0, 1'b1, -1);
    frame(8'hF0, 1'b0, 1'b1, -1);
    frame(8'h75, 1'b0, 1'b1, -1);
    settle("t2");

    frame(8'hE0, 1'b0, 1'b1, -1);
    frame(8'h1C, 1'b1, 1'b1, -1);
    frame(8'h29, 1'b0, 1'b1, -1);
    settle("t3");

    frame(8'h3A, 1'b0, 1'b1, 0);
    frame(8'h5B, 1'b0, 1'b1, 4);
    settle("t4");

    frame(8'hE0, 1'b0, 1'b1, -1);
    model_frame(8'h00, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 6, -1);
    cyc(TO + 50);
    settle("t5_timeout");
    frame(8'h1C, 1'b0, 1'b1, -1);
    settle("t5");

    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      frame(8'hE0, 1'b0, 1'b1, -1);
      else if (r == 1) frame(8'hF0, 1'b0, 1'b1, -1);
      else if (r == 2) frame(rand_code(), 1'b1, 1'b1, -1);
      else if (r == 3) frame(rand_code(), 1'b0, 1'b0, -1);
      else             frame(rand_code(), 1'b0, 1'b1, -1);
    end
    frame(8'h11, 1'b0, 1'b1, -1);
    settle("rand");

    ready = 1'b0;
    last = 8'h00;
    for (int k = 0; k < int'(DEPTH) + 1; k++) begin
      c = rand_code();
      if (k == int'(DEPTH) - 1) last = c;
      frame(c, 1'b0, 1'b1, -1);
    end
    cyc(5);
    chk("t6_level", 32'(level), 32'(exp_q.size()));
    chk("t6_overflow", 32'(overflow), 32'(exp_ovf));
    chk("t6_valid", 32'(valid), 32'd1);
    chk("t6_head", 32'({ext, brk, code}), 32'(exp_q[0]));
    ready = 1'b1;
    settle("t6");
    chk("t6_level_empty", 32'(level), 32'd0);
    chk("t6_ovf_sticky", 32'(overflow), 32'(exp_ovf));
    chk("t6_hold_code", 32'(code), 32'(last));

    send_frame(8'h55, 1'b0, 1'b1, 4, -1);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    model_clear();
    exp_ovf = 1'b0;
    chk("ar_valid", 32'(valid), 32'd0);
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_overflow", 32'(overflow), 32'(exp_ovf));
    chk("ar_code", 32'(code), 32'd0);
    cyc(3);
    rst = 1'b1;
    ps2_data = 1'b1;
    cyc(5);
    frame(8'h1C, 1'b0, 1'b1, -1);
    settle("ar");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
